// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle 16-bit CPU: opcodes, FSM encoding, instruction fields.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOVI = 4'h6;
  localparam logic [3:0] OP_LSH  = 4'h7;
  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_STOR = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_JUMP = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS_MSB  = 3;
  localparam int unsigned RS_LSB  = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  localparam int unsigned REG_IDX_W = 4;

endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file: NREG x DATA_W, two asynchronous read ports, one synchronous write port.
module cpu_mc_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr_a,
  input  logic [REG_IDX_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0]    o_rdata_a,
  output logic [DATA_W-1:0]    o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle 16-bit CPU core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with req/ack memory ports.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned DADDR_W  = 5,
  parameter int unsigned NREG     = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [15:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [1:0]         psr,
  output logic               halted
);

  logic [2:0]        r_state;
  logic [15:0]       r_ir;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_pc_instr;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;
  logic [1:0]        r_psr;

  logic [3:0]        w_op;
  logic [3:0]        w_rd;
  logic [3:0]        w_rs;
  logic [7:0]        w_imm;
  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic [DATA_W-1:0] w_imm_sext;
  logic [PC_W-1:0]   w_br_tgt;
  logic              w_taken;
  logic [7:0]        w_shamt;
  logic [31:0]       w_shamt32;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_link;
  logic [DATA_W-1:0] w_alu;

  assign w_op  = r_ir[OP_MSB:OP_LSB];
  assign w_rd  = r_ir[RD_MSB:RD_LSB];
  assign w_rs  = r_ir[RS_MSB:RS_LSB];
  assign w_imm = r_ir[IMM_MSB:IMM_LSB];

  cpu_mc_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (r_state == ST_WB),
    .i_waddr   (w_rd),
    .i_wdata   (r_res),
    .i_raddr_a (w_rd),
    .i_raddr_b (w_rs),
    .o_rdata_a (w_rf_a),
    .o_rdata_b (w_rf_b)
  );

  assign w_imm_sext = {{(DATA_W-8){w_imm[7]}}, w_imm};
  assign w_br_tgt   = r_pc_instr + {{(PC_W-8){w_imm[7]}}, w_imm};
  assign w_taken    = ((w_op == OP_BEQ) && r_psr[0]) || ((w_op == OP_BNE) && !r_psr[0]);
  assign w_link     = DATA_W'(r_pc_instr + PC_W'(1));

  // Negative imm8 is a logical right shift by its magnitude; -128 yields magnitude 128.
  assign w_shamt   = w_imm[7] ? (8'd0 - w_imm) : w_imm;
  assign w_shamt32 = {24'd0, w_shamt};
  assign w_shift   = (w_shamt32 >= DATA_W) ? '0 :
                     (w_imm[7] ? (r_a >> w_shamt) : (r_a << w_shamt));

  always_comb begin
    w_alu = r_a;
    case (w_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_ADDI: w_alu = r_a + w_imm_sext;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_MOVI: w_alu = {{(DATA_W-8){1'b0}}, w_imm};
      OP_LSH:  w_alu = w_shift;
      OP_JAL:  w_alu = w_link;
      default: w_alu = r_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH;
      r_ir       <= '0;
      r_pc       <= PC_W'(RESET_PC);
      r_pc_instr <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_psr      <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_pc_instr <= r_pc;
            r_pc       <= r_pc + PC_W'(1);
            r_state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_a     <= w_rf_a;
          r_b     <= w_rf_b;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_res <= w_alu;
          case (w_op)
            OP_CMP: begin
              r_psr   <= {($signed(r_a) < $signed(r_b)), (r_a == r_b)};
              r_state <= ST_FETCH;
            end
            OP_BEQ, OP_BNE: begin
              if (w_taken) r_pc <= w_br_tgt;
              r_state <= ST_FETCH;
            end
            OP_JUMP: begin
              r_pc    <= PC_W'(r_b);
              r_state <= ST_FETCH;
            end
            OP_LOAD, OP_STOR: r_state <= ST_MEM;
            OP_HALT:          r_state <= ST_HALT;
            default:          r_state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (w_op == OP_STOR) begin
              r_state <= ST_FETCH;
            end else begin
              r_res   <= dmem_rdata;
              r_state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          if (w_op == OP_JAL) r_pc <= PC_W'(r_b);
          r_state <= ST_FETCH;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Requests are gated by rst_n so a reset abandons any in-flight access at once.
  assign imem_req   = rst_n && (r_state == ST_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = rst_n && (r_state == ST_MEM);
  assign dmem_we    = (w_op == OP_STOR);
  assign dmem_addr  = r_b[DADDR_W-1:0];
  assign dmem_wdata = r_a;
  assign pc         = r_pc;
  assign psr        = r_psr;
  assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed-program bench for cpu_multicycle with wait-state instruction/data memory models.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [4:0]  dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic [15:0] pc;
  logic [1:0]  psr;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_multicycle dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .psr        (psr),
    .halted     (halted)
  );

  // Memory models with programmable wait states
  logic [15:0] imem [256];
  logic [15:0] dmem [32];
  logic        dmem_clr = 1'b0;
  int          i_wait = 0;
  int          d_wait = 0;
  int          i_cnt, d_cnt;

  assign imem_ack   = imem_req && (i_cnt >= i_wait);
  assign imem_rdata = imem[imem_addr[7:0]];
  assign dmem_ack   = dmem_req && (d_cnt >= d_wait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt <= 0;
      d_cnt <= 0;
    end else begin
      i_cnt <= (imem_req && !imem_ack) ? i_cnt + 1 : 0;
      d_cnt <= (dmem_req && !dmem_ack) ? d_cnt + 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (dmem_clr) begin
      for (int i = 0; i < 32; i++) dmem[i] <= 16'h0000;
    end else if (dmem_req && dmem_ack && dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
    end
  end

  // Bus monitor, sampled mid-cycle
  logic [15:0] f_addr [$];
  logic [1:0]  f_psr [$];
  int          ireq_cycles = 0;
  int          st_cycles = 0;
  int          ld_cycles = 0;
  int          st_changes = 0;
  logic        st_prev = 1'b0;
  logic [4:0]  st_addr = '0;
  logic [15:0] st_wdata = '0;

  always @(negedge clk) begin
    if (imem_req && imem_ack) begin
      f_addr.push_back(imem_addr);
      f_psr.push_back(psr);
    end
    if (imem_req) ireq_cycles <= ireq_cycles + 1;
    if (dmem_req && !dmem_we) ld_cycles <= ld_cycles + 1;
    if (dmem_req && dmem_we) begin
      st_cycles <= st_cycles + 1;
      if (st_prev && (dmem_addr != st_addr || dmem_wdata != st_wdata))
        st_changes <= st_changes + 1;
      st_addr  <= dmem_addr;
      st_wdata <= dmem_wdata;
    end
    st_prev <= dmem_req && dmem_we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  // Holds reset two cycles (clearing data RAM), releases just after a rising edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    dmem_clr = 1'b1;
    @(posedge clk);
    #1 dmem_clr = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
    n_checks++;
    if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_req: got %b want 0", dmem_req); end
    n_checks++;
    if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", pc); end
    n_checks++;
    if (psr !== 2'b00) begin n_fail++; $display("FAIL rst_psr: got %b want 00", psr); end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL rst_first_fetch: req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
    end
  endtask

  // MOVI R1,5; MOVI R2,3; ADD R1,R2 with a configurable fetch wait.
  task automatic test_alu_basic(input int iw);
    int base;
    int n_cyc;
    clear_prog();
    imem[0] = 16'h6105;
    imem[1] = 16'h6203;
    imem[2] = 16'h0102;
    i_wait = iw;
    d_wait = 0;
    n_cyc = 3 * (4 + iw);
    do_reset();
    base = f_addr.size();
    repeat (n_cyc - 1) @(posedge clk);
    #1;
    n_checks++;
    if (dut.u_rf.r_mem[1] !== 16'h0005) begin
      n_fail++; $display("FAIL alu_pre_wb_w%0d: R1=%h want 0005", iw, dut.u_rf.r_mem[1]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.u_rf.r_mem[1] !== 16'h0008) begin
      n_fail++; $display("FAIL alu_add_w%0d: R1=%h want 0008", iw, dut.u_rf.r_mem[1]);
    end
    n_checks++;
    if (pc !== 16'h0003) begin n_fail++; $display("FAIL alu_pc_w%0d: got %h want 0003", iw, pc); end
    n_checks++;
    if (f_addr.size() - base != 3) begin
      n_fail++; $display("FAIL alu_nfetch_w%0d: got %0d want 3", iw, f_addr.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (f_addr[base+k] !== 16'(k)) begin
          n_fail++; $display("FAIL alu_fetch_addr[%0d]: got %h want %h", k, f_addr[base+k], 16'(k));
        end
      end
    end
  endtask

  task automatic test_addi_lsh();
    bit ok;
    clear_prog();
    imem[0] = 16'h6100;
    imem[1] = 16'h11FF;
    imem[2] = 16'h6201;
    imem[3] = 16'h720F;
    imem[4] = 16'h63FF;
    imem[5] = 16'h7310;
    imem[6] = 16'h64FF;
    imem[7] = 16'h74F0;
    imem[8] = 16'h65FF;
    imem[9] = 16'h75FF;
    i_wait = 0;
    d_wait = 0;
    do_reset();
    // run ADDI alone first, then the rest
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (dut.u_rf.r_mem[1] !== 16'hFFFF) begin
      n_fail++; $display("FAIL addi_neg: R1=%h want ffff", dut.u_rf.r_mem[1]);
    end
    imem[10] = 16'h71FC;
    wait_halt(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL lsh_halt: halted=%b want 1", halted); end
    n_checks++;
    if (dut.u_rf.r_mem[1] !== 16'h0FFF) begin
      n_fail++; $display("FAIL lsh_right4: R1=%h want 0fff", dut.u_rf.r_mem[1]);
    end
    n_checks++;
    if (dut.u_rf.r_mem[2] !== 16'h8000) begin
      n_fail++; $display("FAIL lsh_left15: R2=%h want 8000", dut.u_rf.r_mem[2]);
    end
    n_checks++;
    if (dut.u_rf.r_mem[3] !== 16'h0000) begin
      n_fail++; $display("FAIL lsh_left16: R3=%h want 0000", dut.u_rf.r_mem[3]);
    end
    n_checks++;
    if (dut.u_rf.r_mem[4] !== 16'h0000) begin
      n_fail++; $display("FAIL lsh_right16: R4=%h want 0000", dut.u_rf.r_mem[4]);
    end
    n_checks++;
    if (dut.u_rf.r_mem[5] !== 16'h007F) begin
      n_fail++; $display("FAIL lsh_right1: R5=%h want 007f", dut.u_rf.r_mem[5]);
    end
  endtask

  task automatic test_logic();
    bit ok;
    clear_prog();
    imem[0]  = 16'h610C;
    imem[1]  = 16'h620A;
    imem[2]  = 16'h630C;
    imem[3]  = 16'h640C;
    imem[4]  = 16'h650C;
    imem[5]  = 16'h3302;
    imem[6]  = 16'h4402;
    imem[7]  = 16'h5502;
    imem[8]  = 16'h2102;
    imem[9]  = 16'h6600;
    imem[10] = 16'h2602;
    imem[11] = 16'h67FF;
    i_wait = 0;
    d_wait = 0;
    do_reset();
    wait_halt(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL logic_halt: halted=%b want 1", halted); end
    n_checks++;
    if (dut.u_rf.r_mem[3] !== 16'h0008) begin n_fail++; $display("FAIL and: R3=%h want 0008", dut.u_rf.r_mem[3]); end
    n_checks++;
    if (dut.u_rf.r_mem[4] !== 16'h000E) begin n_fail++; $display("FAIL or: R4=%h want 000e", dut.u_rf.r_mem[4]); end
    n_checks++;
    if (dut.u_rf.r_mem[5] !== 16'h0006) begin n_fail++; $display("FAIL xor: R5=%h want 0006", dut.u_rf.r_mem[5]); end
    n_checks++;
    if (dut.u_rf.r_mem[1] !== 16'h0002) begin n_fail++; $display("FAIL sub: R1=%h want 0002", dut.u_rf.r_mem[1]); end
    n_checks++;
    if (dut.u_rf.r_mem[6] !== 16'hFFF6) begin n_fail++; $display("FAIL sub_wrap: R6=%h want fff6", dut.u_rf.r_mem[6]); end
    n_checks++;
    if (dut.u_rf.r_mem[7] !== 16'h00FF) begin n_fail++; $display("FAIL movi_zext: R7=%h want 00ff", dut.u_rf.r_mem[7]); end
    n_checks++;
    if (psr !== 2'b00) begin n_fail++; $display("FAIL psr_untouched: got %b want 00", psr); end
  endtask

  task automatic test_mem();
    bit ok;
    int st0, ld0, ch0;
    clear_prog();
    imem[0] = 16'h63BE;
    imem[1] = 16'h7308;
    imem[2] = 16'h69EF;
    imem[3] = 16'h4309;
    imem[4] = 16'h6407;
    imem[5] = 16'h9304;
    imem[6] = 16'h8504;
    i_wait = 0;
    d_wait = 2;
    do_reset();
    st0 = st_cycles;
    ld0 = ld_cycles;
    ch0 = st_changes;
    wait_halt(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mem_halt: halted=%b want 1", halted); end
    n_checks++;
    if (st_cycles - st0 != 3) begin n_fail++; $display("FAIL stor_req_cycles: got %0d want 3", st_cycles - st0); end
    n_checks++;
    if (st_addr !== 5'd7) begin n_fail++; $display("FAIL stor_addr: got %0d want 7", st_addr); end
    n_checks++;
    if (st_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL stor_wdata: got %h want beef", st_wdata); end
    n_checks++;
    if (st_changes - ch0 != 0) begin n_fail++; $display("FAIL stor_stable: got %0d changes want 0", st_changes - ch0); end
    n_checks++;
    if (dmem[7] !== 16'hBEEF) begin n_fail++; $display("FAIL stor_ram: mem[7]=%h want beef", dmem[7]); end
    n_checks++;
    if (ld_cycles - ld0 != 3) begin n_fail++; $display("FAIL load_req_cycles: got %0d want 3", ld_cycles - ld0); end
    n_checks++;
    if (dut.u_rf.r_mem[5] !== 16'hBEEF) begin n_fail++; $display("FAIL load_data: R5=%h want beef", dut.u_rf.r_mem[5]); end
  endtask

  task automatic test_branch();
    bit ok;
    int base;
    int exp_seq [15] = '{0, 1, 2, 3, 8, 9, 10, 8, 9, 10, 11, 12, 13, 14, 18};
    clear_prog();
    imem[0]  = 16'h6200;
    imem[1]  = 16'h6301;
    imem[2]  = 16'h6708;
    imem[3]  = 16'hE007;
    for (int k = 4; k < 8; k++) imem[k] = 16'h66AA;
    imem[8]  = 16'h1201;
    imem[9]  = 16'hA203;
    imem[10] = 16'hB0FE;
    imem[11] = 16'h6403;
    imem[12] = 16'h6505;
    imem[13] = 16'hA405;
    imem[14] = 16'hC004;
    for (int k = 15; k < 18; k++) imem[k] = 16'h66AA;
    i_wait = 0;
    d_wait = 0;
    do_reset();
    base = f_addr.size();
    wait_halt(400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL br_halt: halted=%b want 1", halted); end
    n_checks++;
    if (f_addr.size() - base != 15) begin
      n_fail++; $display("FAIL br_nfetch: got %0d want 15", f_addr.size() - base);
    end else begin
      for (int k = 0; k < 15; k++) begin
        n_checks++;
        if (f_addr[base+k] !== 16'(exp_seq[k])) begin
          n_fail++; $display("FAIL br_fetch[%0d]: got %h want %h", k, f_addr[base+k], 16'(exp_seq[k]));
        end
      end
      n_checks++;
      if (f_psr[base+7] !== 2'b01) begin n_fail++; $display("FAIL cmp_eq_psr: got %b want 01", f_psr[base+7]); end
      n_checks++;
      if (f_psr[base+10] !== 2'b00) begin n_fail++; $display("FAIL cmp_gt_psr: got %b want 00", f_psr[base+10]); end
    end
    n_checks++;
    if (psr !== 2'b10) begin n_fail++; $display("FAIL cmp_lt_psr: got %b want 10", psr); end
    n_checks++;
    if (dut.u_rf.r_mem[6] !== 16'h0000) begin n_fail++; $display("FAIL br_skipped: R6=%h want 0000", dut.u_rf.r_mem[6]); end
    n_checks++;
    if (dut.u_rf.r_mem[2] !== 16'h0002) begin n_fail++; $display("FAIL br_loop_count: R2=%h want 0002", dut.u_rf.r_mem[2]); end
    n_checks++;
    if (pc !== 16'd19) begin n_fail++; $display("FAIL br_halt_pc: got %h want 0013", pc); end
  endtask

  task automatic test_jal_halt();
    bit ok;
    int base;
    int ir0;
    int exp_seq [5] = '{0, 1, 2, 20, 64};
    clear_prog();
    imem[0]  = 16'h6740;
    imem[1]  = 16'h6814;
    imem[2]  = 16'hE008;
    imem[20] = 16'hD607;
    i_wait = 0;
    d_wait = 0;
    do_reset();
    base = f_addr.size();
    wait_halt(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL jal_halt: halted=%b want 1", halted); end
    n_checks++;
    if (f_addr.size() - base != 5) begin
      n_fail++; $display("FAIL jal_nfetch: got %0d want 5", f_addr.size() - base);
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (f_addr[base+k] !== 16'(exp_seq[k])) begin
          n_fail++; $display("FAIL jal_fetch[%0d]: got %h want %h", k, f_addr[base+k], 16'(exp_seq[k]));
        end
      end
    end
    n_checks++;
    if (dut.u_rf.r_mem[6] !== 16'd21) begin n_fail++; $display("FAIL jal_link: R6=%h want 0015", dut.u_rf.r_mem[6]); end
    n_checks++;
    if (pc !== 16'h0041) begin n_fail++; $display("FAIL halt_pc: got %h want 0041", pc); end
    ir0 = ireq_cycles;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (ireq_cycles - ir0 != 0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_quiet: %0d imem_req cycles want 0", ireq_cycles - ir0);
    end
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: halted=%b want 1", halted); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clear_prog();
    imem[0] = 16'h6407;
    imem[1] = 16'h6155;
    imem[2] = 16'h9104;
    i_wait = 0;
    d_wait = 10;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (dmem_req) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rmid_dreq_seen: dmem_req=%b want 1", dmem_req); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_dreq_drop: got %b want 0", dmem_req); end
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_ireq: got %b want 0", imem_req); end
    n_checks++;
    if (pc !== 16'h0000) begin n_fail++; $display("FAIL rmid_pc: got %h want 0000", pc); end
    n_checks++;
    if (dut.u_rf.r_mem[1] !== 16'h0000 || dut.u_rf.r_mem[4] !== 16'h0000) begin
      n_fail++; $display("FAIL rmid_regs: R1=%h R4=%h want 0000", dut.u_rf.r_mem[1], dut.u_rf.r_mem[4]);
    end
    n_checks++;
    if (dmem[7] !== 16'h0000) begin n_fail++; $display("FAIL rmid_abandon: mem[7]=%h want 0000", dmem[7]); end
    d_wait = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL rmid_refetch: req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
    end
    wait_halt(200, ok);
    n_checks++;
    if (!ok || dmem[7] !== 16'h0055) begin
      n_fail++; $display("FAIL rmid_rerun: halted=%b mem[7]=%h want 1/0055", halted, dmem[7]);
    end
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_alu_basic(0);
    test_alu_basic(1);
    test_addi_lsh();
    test_logic();
    test_mem();
    test_branch();
    test_jal_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
